// File: rtl/rstseq_n.sv
// Reset sequencer: holds NCH channels after rst, releases them in index order,
// then services per-channel soft resets. Optional feature macro: RSTSEQ_SOFTRST_EN.
module rstseq_n #(
   parameter int NCH  = 22,
   parameter int HOLD = 16,
   parameter int STEP = 4,
   parameter int PW   = 8,
   parameter int CNTW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           scanmode,
   input  logic [NCH-1:0] rstmsk,
   input  logic [NCH-1:0] swrst,
   output logic [NCH-1:0] orst_,
   output logic           done,
   output logic           busy
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CNTW-1:0] HOLD_C   = CNTW'(HOLD);
   localparam logic [CNTW-1:0] STEP_M1  = CNTW'(STEP - 1);
   localparam logic [IW-1:0]   LAST_IDX = IW'(NCH - 1);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_REL  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t          state_r;
   logic [CNTW-1:0] cnt_r;
   logic [IW-1:0]   idx_r;
   logic [NCH-1:0]  orst_r;
   logic            done_r;
   logic            busy_r;
   logic [NCH-1:0]  soft_nxt_s;
   logic [CNTW-1:0] run_cnt_s;

`ifdef RSTSEQ_SOFTRST_EN
   localparam logic [CNTW-1:0] PW_M1 = CNTW'(PW - 1);
   logic [NCH-1:0] softheld_r;
   logic [NCH-1:0] msk_q_r;
   logic [NCH-1:0] soft_req_s;

   // Soft-reset window: a mask release counts as a request; new requests restart the window
   always_comb begin
      soft_req_s = (swrst & ~rstmsk) | (msk_q_r & ~rstmsk);
      soft_nxt_s = softheld_r;
      run_cnt_s  = cnt_r;
      if (state_r != ST_RUN) begin
         soft_nxt_s = {NCH{1'b0}};
         run_cnt_s  = cnt_r;
      end else if (|soft_req_s) begin
         soft_nxt_s = softheld_r | soft_req_s;
         run_cnt_s  = {CNTW{1'b0}};
      end else if (|softheld_r) begin
         if (cnt_r == PW_M1) begin
            soft_nxt_s = {NCH{1'b0}};
            run_cnt_s  = {CNTW{1'b0}};
         end else begin
            soft_nxt_s = softheld_r;
            run_cnt_s  = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
         end
      end else begin
         soft_nxt_s = softheld_r;
         run_cnt_s  = {CNTW{1'b0}};
      end
   end

   // Held-channel vector and previous mask for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         softheld_r <= {NCH{1'b0}};
         msk_q_r    <= rstmsk;
      end else begin
         softheld_r <= soft_nxt_s;
         msk_q_r    <= rstmsk;
      end
   end
`else
   logic unused_swrst_s;
   assign unused_swrst_s = ^swrst;
   assign soft_nxt_s     = {NCH{1'b0}};
   assign run_cnt_s      = {CNTW{1'b0}};
`endif

   // Sequencer FSM; E0 samples cnt=0, so cnt equals HOLD on edge E0+HOLD
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_HOLD;
         cnt_r   <= {CNTW{1'b0}};
         idx_r   <= {IW{1'b0}};
         orst_r  <= {NCH{1'b0}};
         done_r  <= 1'b0;
         busy_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_HOLD: begin
               done_r <= 1'b0;
               busy_r <= 1'b1;
               if (cnt_r == HOLD_C) begin
                  cnt_r     <= {CNTW{1'b0}};
                  orst_r[0] <= ~rstmsk[0];
                  if (NCH == 1) begin
                     state_r <= ST_RUN;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= ST_REL;
                     idx_r   <= IW'(1);
                  end
               end else begin
                  cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
               end
            end
            ST_REL: begin
               if (cnt_r == STEP_M1) begin
                  cnt_r         <= {CNTW{1'b0}};
                  orst_r[idx_r] <= ~rstmsk[idx_r];
                  if (idx_r == LAST_IDX) begin
                     state_r <= ST_RUN;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end else begin
                  cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
               end
            end
            ST_RUN: begin
               cnt_r  <= run_cnt_s;
               orst_r <= ~rstmsk & ~soft_nxt_s;
               done_r <= 1'b1;
               busy_r <= |soft_nxt_s;
            end
            default: begin
               state_r <= ST_HOLD;
               cnt_r   <= {CNTW{1'b0}};
               idx_r   <= {IW{1'b0}};
               orst_r  <= {NCH{1'b0}};
               done_r  <= 1'b0;
               busy_r  <= 1'b1;
            end
         endcase
      end
   end

   assign orst_ = scanmode ? {NCH{~rst}} : orst_r;
   assign done  = done_r;
   assign busy  = busy_r;

endmodule

// File: tb/tb_rstseq_n.sv
// Directed bench for rstseq_n (NCH=4, HOLD=16, STEP=4, PW=8); adapts soft-reset
// expectations to whether RSTSEQ_SOFTRST_EN is defined.
module tb_rstseq_n;

   logic       clk;
   logic       rst;
   logic       scanmode;
   logic [3:0] rstmsk;
   logic [3:0] swrst;
   logic [3:0] orst_;
   logic       done;
   logic       busy;

   int total;
   int bad;
   int e;

`ifdef RSTSEQ_SOFTRST_EN
   localparam bit SOFT = 1'b1;
`else
   localparam bit SOFT = 1'b0;
`endif

   rstseq_n #(.NCH(4), .HOLD(16), .STEP(4), .PW(8), .CNTW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .scanmode (scanmode),
      .rstmsk   (rstmsk),
      .swrst    (swrst),
      .orst_    (orst_),
      .done     (done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance until edge number 'target' (relative to E0) has passed, sample 1 time unit later
   task automatic adv_to(input int target);
      while (e < target) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   task automatic do_reset(input logic [3:0] msk);
      rst    = 1'b1;
      rstmsk = msk;
      swrst  = 4'b0000;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_orst", {28'd0, orst_}, 32'h0);
      chk("rst_done", {31'd0, done}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h1);
      rst = 1'b0;
      e   = -1;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      e        = 0;
      rst      = 1'b1;
      scanmode = 1'b0;
      rstmsk   = 4'b0000;
      swrst    = 4'b0000;

      // release sequence, no mask
      do_reset(4'b0000);
      adv_to(15); chk("seq_e15",  {28'd0, orst_}, 32'h0);
      adv_to(16); chk("seq_e16",  {28'd0, orst_}, 32'h1);
      adv_to(19); chk("seq_e19",  {28'd0, orst_}, 32'h1);
      adv_to(20); chk("seq_e20",  {28'd0, orst_}, 32'h3);
      adv_to(24); chk("seq_e24",  {28'd0, orst_}, 32'h7);
      adv_to(27); chk("seq_e27",  {28'd0, orst_}, 32'h7);
                  chk("done_e27", {31'd0, done},  32'h0);
                  chk("busy_e27", {31'd0, busy},  32'h1);
      adv_to(28); chk("seq_e28",  {28'd0, orst_}, 32'hf);
                  chk("done_e28", {31'd0, done},  32'h1);
                  chk("busy_e28", {31'd0, busy},  32'h0);

      // release with channel 2 masked
      do_reset(4'b0100);
      adv_to(16); chk("msk_e16", {28'd0, orst_}, 32'h1);
      adv_to(20); chk("msk_e20", {28'd0, orst_}, 32'h3);
      adv_to(24); chk("msk_e24", {28'd0, orst_}, 32'h3);
      adv_to(28); chk("msk_e28", {28'd0, orst_}, 32'hb);
                  chk("msk_done", {31'd0, done}, 32'h1);

      // single soft reset on ch1, Es = 29
      swrst = 4'b0010;
      adv_to(29);
      swrst = 4'b0000;
      chk("sw1_es1",  {28'd0, orst_}, SOFT ? 32'h9 : 32'hb);
      chk("sw1_busy", {31'd0, busy},  SOFT ? 32'h1 : 32'h0);
      adv_to(36); chk("sw1_es8m", {28'd0, orst_}, SOFT ? 32'h9 : 32'hb);
      adv_to(37); chk("sw1_es8",  {28'd0, orst_}, 32'hb);
                  chk("sw1_idle", {31'd0, busy},  32'h0);

      // overlapping requests: ch0 at Es=38, ch3 at Es+5=43, release at 51
      swrst = 4'b0001;
      adv_to(38);
      swrst = 4'b0000;
      chk("sw2_a", {28'd0, orst_}, SOFT ? 32'ha : 32'hb);
      adv_to(42);
      swrst = 4'b1000;
      adv_to(43);
      swrst = 4'b0000;
      chk("sw2_b", {28'd0, orst_}, SOFT ? 32'h2 : 32'hb);
      adv_to(50); chk("sw2_e50", {28'd0, orst_}, SOFT ? 32'h2 : 32'hb);
      adv_to(51); chk("sw2_e51", {28'd0, orst_}, 32'hb);

      // mask set on ch1 in RUN, then ch2 unmasked
      rstmsk = 4'b0110;
      adv_to(52); chk("mskset", {28'd0, orst_}, 32'h9);
      rstmsk = 4'b0010;
      adv_to(53); chk("mskclr_a", {28'd0, orst_}, SOFT ? 32'h9 : 32'hd);
      adv_to(60); chk("mskclr_b", {28'd0, orst_}, SOFT ? 32'h9 : 32'hd);
      adv_to(61); chk("mskclr_c", {28'd0, orst_}, 32'hd);

      // rst during REL after ch1 released
      do_reset(4'b0000);
      adv_to(20); chk("rel_e20", {28'd0, orst_}, 32'h3);
      rst = 1'b1;
      adv_to(21);
      chk("rel_rst_orst", {28'd0, orst_}, 32'h0);
      chk("rel_rst_done", {31'd0, done},  32'h0);
      chk("rel_rst_busy", {31'd0, busy},  32'h1);
      rst = 1'b0;
      e   = -1;
      adv_to(15); chk("restart_e15", {28'd0, orst_}, 32'h0);
      adv_to(16); chk("restart_e16", {28'd0, orst_}, 32'h1);

      // scan bypass, combinational from rst regardless of mask/state
      rstmsk   = 4'b1111;
      scanmode = 1'b1;
      #1; chk("scan_rst0", {28'd0, orst_}, 32'hf);
      rst = 1'b1;
      #1; chk("scan_rst1", {28'd0, orst_}, 32'h0);
      rst = 1'b0;
      #1; chk("scan_rst0b", {28'd0, orst_}, 32'hf);
      scanmode = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
